// File: rtl/raw_frame_arbiter_pkg.sv
// Shared types and helpers for the RAW10 frame arbiter.
package raw_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARB    = 2'd1,
    STREAM = 2'd2
  } arb_state_e;

  localparam int ERR_TIMEOUT_BIT = 0;
  localparam int ERR_SHORT_BIT   = 1;
  localparam int N_ERR           = 2;

  function automatic int src_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/raw_frame_arbiter_rr_pick.sv
// Round-robin picker: first requester after ptr, wrapping, wins.
module rr_pick #(
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx,
  output logic             hit
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    gnt  = '0;
    idx  = '0;
    hit  = 1'b0;
    cand = '0;
    for (int k = 1; k <= N; k++) begin
      cand = IDX_W'((int'(ptr) + k) % N);
      if (!hit && req[cand]) begin
        hit       = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/raw_frame_arbiter.sv
// Frame-granular round-robin arbiter sharing one AXI-stream sink between N_SRC cameras.
// state  | meaning
// IDLE   | arbitration disabled, all sources drained to frame start
// ARB    | waiting for a masked source holding a frame-start beat
// STREAM | granted source muxed to the sink until frame end or abort
module raw_frame_arbiter
  import raw_arb_pkg::*;
#(
  parameter int N_SRC       = 2,
  parameter int DATA_WIDTH  = 40,
  parameter int TDEST_WIDTH = 10,
  parameter int FRAME_LINES = 1080,
  parameter int TIMEOUT     = 65535
) (
  input  logic                        I_clk,
  input  logic                        I_rst,
  input  logic                        I_enable,
  input  logic [N_SRC-1:0]            I_src_mask,
  input  logic [N_SRC*DATA_WIDTH-1:0] I_s_tdata,
  input  logic [N_SRC-1:0]            I_s_tvalid,
  input  logic [N_SRC-1:0]            I_s_tuser,
  input  logic [N_SRC-1:0]            I_s_tlast,
  output logic [N_SRC-1:0]            O_s_tready,
  output logic [DATA_WIDTH-1:0]       O_m_tdata,
  output logic                        O_m_tvalid,
  output logic                        O_m_tuser,
  output logic                        O_m_tlast,
  output logic [TDEST_WIDTH-1:0]      O_m_tdest,
  input  logic                        I_m_tready,
  output logic [N_SRC-1:0]            O_grant,
  output logic                        O_busy,
  output logic                        O_frame_done,
  output logic                        O_timeout_err,
  output logic                        O_short_err
);

  localparam int IDX_W  = src_idx_w(N_SRC);
  localparam int LINE_W = $clog2(FRAME_LINES + 1);
  localparam int IDLE_W = $clog2(TIMEOUT + 1);
  localparam logic [LINE_W-1:0] LAST_LINE  = LINE_W'(FRAME_LINES - 1);
  localparam logic [IDLE_W-1:0] IDLE_LIMIT = IDLE_W'(TIMEOUT - 2);

  arb_state_e state_q, state_d;
  logic [N_SRC-1:0]       grant_q, grant_d;
  logic [IDX_W-1:0]       gidx_q, gidx_d;
  logic [IDX_W-1:0]       ptr_q, ptr_d;
  logic [TDEST_WIDTH-1:0] tdest_q, tdest_d;
  logic [LINE_W-1:0]      line_cnt_q, line_cnt_d;
  logic [IDLE_W-1:0]      idle_cnt_q, idle_cnt_d;
  logic                   started_q, started_d;
  logic                   frame_done_q, frame_done_d;
  logic [N_ERR-1:0]       err_q, err_d;

  logic [N_SRC-1:0]      win_gnt;
  logic [IDX_W-1:0]      win_idx;
  logic                  win_hit;
  logic [DATA_WIDTH-1:0] g_data;
  logic                  g_valid, g_user, g_last;
  logic                  in_stream, early, fwd_valid, accept, last_beat, idle_abort;

  rr_pick #(
    .N     (N_SRC),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req (I_src_mask & I_s_tvalid & I_s_tuser),
    .ptr (ptr_q),
    .gnt (win_gnt),
    .idx (win_idx),
    .hit (win_hit)
  );

  always_comb begin
    g_data  = '0;
    g_valid = 1'b0;
    g_user  = 1'b0;
    g_last  = 1'b0;
    for (int i = 0; i < N_SRC; i++) begin
      if (gidx_q == IDX_W'(i)) begin
        g_data  = I_s_tdata[i*DATA_WIDTH +: DATA_WIDTH];
        g_valid = I_s_tvalid[i];
        g_user  = I_s_tuser[i];
        g_last  = I_s_tlast[i];
      end
    end
  end

  assign in_stream  = (state_q == STREAM);
  // A frame-start beat after the frame began is held back for re-arbitration.
  assign early      = in_stream & started_q & g_valid & g_user;
  assign fwd_valid  = in_stream & g_valid & ~early;
  assign accept     = fwd_valid & I_m_tready;
  assign last_beat  = accept & g_last & (line_cnt_q == LAST_LINE);
  assign idle_abort = in_stream & ~g_valid & (idle_cnt_q == IDLE_LIMIT);

  assign O_m_tvalid    = fwd_valid;
  assign O_m_tdata     = fwd_valid ? g_data : '0;
  assign O_m_tuser     = fwd_valid & g_user & ~started_q;
  assign O_m_tlast     = fwd_valid & g_last;
  assign O_m_tdest     = tdest_q;
  assign O_grant       = grant_q;
  assign O_busy        = in_stream;
  assign O_frame_done  = frame_done_q;
  assign O_timeout_err = err_q[ERR_TIMEOUT_BIT];
  assign O_short_err   = err_q[ERR_SHORT_BIT];

  always_comb begin
    O_s_tready = ~I_s_tuser;
    for (int i = 0; i < N_SRC; i++) begin
      if (in_stream && gidx_q == IDX_W'(i)) O_s_tready[i] = I_m_tready & ~early;
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    gidx_d       = gidx_q;
    ptr_d        = ptr_q;
    tdest_d      = tdest_q;
    line_cnt_d   = line_cnt_q;
    idle_cnt_d   = idle_cnt_q;
    started_d    = started_q;
    err_d        = err_q;
    frame_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (I_enable) state_d = ARB;
      end
      ARB: begin
        if (!I_enable) begin
          state_d = IDLE;
        end else if (win_hit) begin
          state_d = STREAM;
          grant_d = win_gnt;
          gidx_d  = win_idx;
          tdest_d = TDEST_WIDTH'(win_idx);
        end
      end
      STREAM: begin
        if (accept) started_d = 1'b1;
        if (accept && g_last) line_cnt_d = line_cnt_q + LINE_W'(1);
        idle_cnt_d = g_valid ? '0 : idle_cnt_q + IDLE_W'(1);
        if (last_beat || early || idle_abort) begin
          frame_done_d = 1'b1;
          ptr_d        = gidx_q;
          grant_d      = '0;
          started_d    = 1'b0;
          line_cnt_d   = '0;
          idle_cnt_d   = '0;
          state_d      = (last_beat && !I_enable) ? IDLE : ARB;
          if (early)      err_d[ERR_SHORT_BIT]   = 1'b1;
          if (idle_abort) err_d[ERR_TIMEOUT_BIT] = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      gidx_q       <= '0;
      ptr_q        <= IDX_W'(N_SRC - 1);
      tdest_q      <= '0;
      line_cnt_q   <= '0;
      idle_cnt_q   <= '0;
      started_q    <= 1'b0;
      frame_done_q <= 1'b0;
      err_q        <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      gidx_q       <= gidx_d;
      ptr_q        <= ptr_d;
      tdest_q      <= tdest_d;
      line_cnt_q   <= line_cnt_d;
      idle_cnt_q   <= idle_cnt_d;
      started_q    <= started_d;
      frame_done_q <= frame_done_d;
      err_q        <= err_d;
    end
  end

endmodule

// File: tb/tb_raw_frame_arbiter.sv
// Directed bench for raw_frame_arbiter with small frames (4 lines x 8 beats).
module tb_raw_frame_arbiter;

  localparam int N   = 2;
  localparam int DW  = 40;
  localparam int TW  = 10;
  localparam int FL  = 4;
  localparam int TO  = 16;
  localparam int BPF = FL * 8;

  logic            clk = 1'b0;
  logic            rst, en_arb, m_tready;
  logic [N-1:0]    mask, s_tvalid, s_tuser, s_tlast, s_tready, grant;
  logic [N*DW-1:0] s_tdata;
  logic [DW-1:0]   m_tdata;
  logic            m_tvalid, m_tuser, m_tlast, busy, fdone, terr, serr;
  logic [TW-1:0]   m_tdest;

  int n_cmp = 0;
  int n_err = 0;

  int pos [N];
  int frm [N];
  bit gen_en [N];
  bit tog, sb_on;
  int exp_src, exp_frm, exp_b;

  logic [N-1:0]  sn_sv, sn_sr, sn_grant;
  logic          sn_mv, sn_mr, sn_mu, sn_ml, sn_fd, sn_busy, sn_terr, sn_serr;
  logic [DW-1:0] sn_md;
  logic [TW-1:0] sn_dest;

  always #5 clk = ~clk;

  raw_frame_arbiter #(
    .N_SRC(N), .DATA_WIDTH(DW), .TDEST_WIDTH(TW), .FRAME_LINES(FL), .TIMEOUT(TO)
  ) dut (
    .I_clk(clk), .I_rst(rst), .I_enable(en_arb), .I_src_mask(mask),
    .I_s_tdata(s_tdata), .I_s_tvalid(s_tvalid), .I_s_tuser(s_tuser), .I_s_tlast(s_tlast),
    .O_s_tready(s_tready), .O_m_tdata(m_tdata), .O_m_tvalid(m_tvalid), .O_m_tuser(m_tuser),
    .O_m_tlast(m_tlast), .O_m_tdest(m_tdest), .I_m_tready(m_tready), .O_grant(grant),
    .O_busy(busy), .O_frame_done(fdone), .O_timeout_err(terr), .O_short_err(serr)
  );

  function automatic logic [DW-1:0] mk(input int s, input int f, input int b);
    return (DW'(s) << 16) | (DW'(f) << 8) | DW'(b);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      s_tvalid[i]             = gen_en[i];
      s_tuser[i]              = (pos[i] == 0);
      s_tlast[i]              = (pos[i] % 8 == 7);
      s_tdata[i*DW +: DW]     = mk(i, frm[i], pos[i]);
    end
  endtask

  task automatic set_exp(input int s, input int f);
    exp_src = s;
    exp_frm = f;
    exp_b   = 0;
    sb_on   = 1'b1;
  endtask

  // Sample mid-cycle, then advance the source models after the clock edge.
  task automatic cyc();
    @(negedge clk);
    sn_sv = s_tvalid;  sn_sr = s_tready;  sn_grant = grant;
    sn_mv = m_tvalid;  sn_mr = m_tready;  sn_mu = m_tuser;  sn_ml = m_tlast;
    sn_md = m_tdata;   sn_dest = m_tdest; sn_fd = fdone;    sn_busy = busy;
    sn_terr = terr;    sn_serr = serr;
    if (sb_on && sn_mv && sn_mr) begin
      chk("beat_data", sn_md, mk(exp_src, exp_frm, exp_b));
      chk("beat_dest", sn_dest, exp_src);
      chk("beat_user", sn_mu, exp_b == 0);
      chk("beat_last", sn_ml, exp_b % 8 == 7);
      exp_b++;
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (sn_sv[i] && sn_sr[i]) begin
        pos[i]++;
        if (pos[i] == BPF) begin
          pos[i] = 0;
          frm[i]++;
        end
      end
    end
    if (tog) m_tready = ~m_tready;
    drive();
  endtask

  task automatic wait_out(input int target, input string tag);
    int n = 0;
    while (exp_b < target && n < 400) begin
      cyc();
      n++;
    end
    chk(tag, exp_b, target);
  endtask

  initial begin
    rst = 1'b1; en_arb = 1'b0; mask = 2'b11; m_tready = 1'b1; tog = 1'b0; sb_on = 1'b0;
    exp_src = 0; exp_frm = 0; exp_b = 0;
    for (int i = 0; i < N; i++) begin
      pos[i] = 0; frm[i] = 0; gen_en[i] = 1'b1;
    end
    drive();
    cyc(); cyc();
    chk("rst_grant", sn_grant, 0);
    chk("rst_busy", sn_busy, 0);
    chk("rst_mvalid", sn_mv, 0);
    chk("rst_tdest", sn_dest, 0);
    chk("rst_tready", sn_sr, 2'b00);
    chk("rst_fd", sn_fd, 0);
    chk("rst_errs", {sn_terr, sn_serr}, 0);

    // Both sources ready: src0 first, then src1.
    rst = 1'b0; en_arb = 1'b1;
    set_exp(0, 0);
    wait_out(4, "s1_f0_start");
    chk("s1_grant0", sn_grant, 2'b01);
    chk("s1_busy", sn_busy, 1);
    chk("s1_fd_mid", sn_fd, 0);
    wait_out(BPF, "s1_f0_len");
    cyc();
    chk("s1_fd0", sn_fd, 1);
    chk("s1_grant_drop", sn_grant, 0);
    set_exp(1, 0);
    wait_out(4, "s1_f1_start");
    chk("s1_grant1", sn_grant, 2'b10);
    chk("s1_tdest1", sn_dest, 1);
    wait_out(BPF, "s1_f1_len");
    cyc();
    chk("s1_fd1", sn_fd, 1);

    // src1 mid-frame while src0 streams: drained, then its frame-start held.
    rst = 1'b1; sb_on = 1'b0;
    cyc();
    pos[0] = 0; frm[0] = 0; pos[1] = 5; frm[1] = 0;
    drive();
    cyc();
    rst = 1'b0;
    set_exp(0, 0);
    wait_out(4, "s2_start");
    chk("s2_drain_open", sn_sr[1], 1);
    wait_out(30, "s2_mid");
    chk("s2_hold_ready", sn_sr[1], 0);
    chk("s2_hold_valid", sn_sv[1], 1);
    wait_out(BPF, "s2_len");
    cyc();
    chk("s2_fd", sn_fd, 1);

    // src1's held beat starts its frame; sink ready toggles every cycle.
    set_exp(1, 1);
    tog = 1'b1;
    wait_out(BPF, "s3_len");
    cyc();
    chk("s3_fd", sn_fd, 1);
    chk("s3_no_timeout", sn_terr, 0);
    tog = 1'b0; m_tready = 1'b1;

    // src0 stalls after two lines.
    set_exp(0, 1);
    wait_out(16, "s4_two_lines");
    gen_en[0] = 1'b0;
    drive();
    for (int c = 0; c < TO - 1; c++) begin
      cyc();
      chk("s4_fd_quiet", sn_fd, 0);
    end
    chk("s4_terr_pre", sn_terr, 0);
    cyc();
    chk("s4_fd_abort", sn_fd, 1);
    chk("s4_terr", sn_terr, 1);
    chk("s4_serr", sn_serr, 0);
    chk("s4_busy", sn_busy, 0);
    set_exp(1, 2);
    gen_en[0] = 1'b1;
    drive();
    wait_out(BPF, "s4_other_len");
    cyc();
    chk("s4_fd_other", sn_fd, 1);

    // src0 restarts its frame after 10 beats.
    mask = 2'b01;
    set_exp(0, 2);
    wait_out(10, "s5_ten");
    pos[0] = 0; frm[0] = 3;
    drive();
    cyc();
    chk("s5_blk_valid", sn_mv, 0);
    chk("s5_blk_ready", sn_sr[0], 0);
    chk("s5_blk_busy", sn_busy, 1);
    cyc();
    chk("s5_fd", sn_fd, 1);
    chk("s5_serr", sn_serr, 1);
    chk("s5_arb", sn_busy, 0);
    set_exp(0, 3);
    wait_out(BPF, "s5_regrant_len");
    cyc();
    chk("s5_fd_full", sn_fd, 1);

    // Enable dropped mid-frame: frame completes, then idle.
    set_exp(0, 4);
    wait_out(8, "s6_mid");
    en_arb = 1'b0;
    wait_out(BPF, "s6_len");
    cyc();
    chk("s6_fd", sn_fd, 1);
    chk("s6_grant", sn_grant, 0);
    cyc();
    chk("s6_idle_busy", sn_busy, 0);
    cyc();
    chk("s6_idle_grant", sn_grant, 0);
    chk("s6_idle_valid", sn_mv, 0);

    // Reset mid-frame.
    en_arb = 1'b1; mask = 2'b11;
    set_exp(1, 3);
    wait_out(5, "s7_mid");
    rst = 1'b1;
    cyc();
    cyc();
    chk("s7_grant", sn_grant, 0);
    chk("s7_busy", sn_busy, 0);
    chk("s7_mvalid", sn_mv, 0);
    chk("s7_mdata", sn_md, 0);
    chk("s7_tdest", sn_dest, 0);
    chk("s7_fd", sn_fd, 0);
    chk("s7_errs", {sn_terr, sn_serr}, 0);
    chk("s7_tready", sn_sr, 2'b10);
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
